bm_logic_rr_sched: RTL and testbench
====================================

// Module: bm_logic_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one pipelined bitwise logic unit among NREQ requesters.
//  Picks at most one requester per cycle and issues its operands and opcode into the unit.
//  Returns each result tagged with the requester id.
//  Sits between micro-benchmark operand sources and the shared AND/OR/XOR datapath.
// PARAMETERS
//  BITS  2  operand/result width
//  NREQ  4  number of requesters (power of 2)
//  IDW   2  requester id width, = log2(NREQ)
// PORTS
//  clock     in   1          single clock; all state updates on posedge
//  reset     in   1          asynchronous, active-high; clears all state
//  hold      in   1          1 = issue nothing this cycle; pipeline keeps draining
//  req       in   NREQ       req[i]=1: requester i has a valid operation
//  a_bus     in   NREQ*BITS  operand A, requester i at [i*BITS +: BITS]
//  b_bus     in   NREQ*BITS  operand B, same packing as a_bus
//  op_bus    in   NREQ*2     opcode, requester i at [i*2 +: 2]
//  gnt       out  NREQ       one-hot grant, combinational, same cycle as req
//  res_valid out  1          result valid, one-cycle pulse per issued op
//  res_id    out  IDW        requester id of res_data
//  res_data  out  BITS       operation result
//  busy      out  1          |req | any pipeline stage valid
// BEHAVIOUR
//  Reset (async, active-high):
//   - rr pointer = 0, so requester 0 has top priority.
//   - All pipeline valids = 0; res_valid/res_id/res_data = 0.
//   - gnt = 0 while reset is high.
//  Handshake:
//   - A requester holds req[i] and its operands stable until it sees gnt[i]=1.
//   - The op is accepted at the clock edge where gnt[i]=1.
//   - The requester may drop req or present new data on the next cycle.
//  Arbitration:
//   - Scan order is ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ); grant the first asserted req.
//   - gnt = 0 if hold=1 or req=0.
//   - On a grant to i, ptr <= (i+1) mod NREQ; otherwise ptr holds.
//   - Fairness: continuously asserted requesters are each served within NREQ cycles.
//  Opcodes: 00 = A&B; 01 = A|B; 10 = A^B; 11 = A&~B.
//   - All ops are bitwise at BITS width; no carries, no extension.
//  Pipeline (2 stages, no backpressure):
//   - S1 registers {valid, id, op, a, b} at the grant edge.
//   - S2 computes f(op,a,b) from S1 and registers {res_valid, res_id, res_data}.
//   - Latency: grant in cycle k -> res_valid=1 in cycle k+2.
//   - Throughput: 1 op/cycle.
//   - When S1 is not valid, res_valid=0 next cycle; res_id and res_data hold their last values.
//  Boundary conditions:
//   - ptr wraps from NREQ-1 to 0.
//   - hold asserted with an op in flight: the op still completes.
//   - hold and req change in the same cycle: only current-cycle values count.
//   - A single requester held high is granted every cycle.
//   - Reset mid-operation: in-flight ops are discarded, with no res_valid pulse after reset releases.
//   - Results are never reordered; res_id follows grant order.
// STRUCTURE
//  Shared defines header bm_logic_defs.vh:
//   - opcode constants OP_AND/OP_OR/OP_XOR/OP_ANDN
//   - default BITS
//  Sub-module bm_logic_unit (BITS):
//   - the S1/S2 pipeline with op decode; inputs clock, reset, vld, id, op, a, b
//   - the scheduler instantiates exactly one of these
//  The top holds the rr pointer, the priority scan and the operand mux.
// TESTING
//  1 Reset: reset=1 with req=4'b1111 -> gnt=0, res_valid=0; after release, first gnt=4'b0001.
//  2 Round robin: req=4'b1111 held for 8 cycles -> gnt sequence 1,2,4,8,1,2,4,8; res_id 0,1,2,3,... two cycles later.
//  3 Op/latency: only req[2], a=2'b10, b=2'b11, op=11 -> gnt[2] in cycle k; cycle k+2 gives res_valid=1, res_id=2, res_data=2'b00.
//    Repeat with op 00/01/10 -> 10/11/01.
//  4 Hold: req=4'b0011 with hold=1 for 3 cycles -> gnt=0, ptr unchanged; op granted one cycle before hold still returns at +2.
//  5 Wrap and skip: ptr=3 with req=4'b0101 -> gnt=4'b0001, then 4'b0100, then 4'b0001.
//  6 Reset mid-flight: assert reset one cycle after a grant -> no res_valid before the next new grant+2.

Source files
------------

// File: rtl/bm_logic_rr_sched_pkg.sv
// Shared opcode encoding and default width for the round-robin logic-unit scheduler.
package bm_logic_rr_sched_pkg;

  localparam int BITS_DEF = 2;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

endpackage

// File: rtl/bm_logic_unit.sv
// Two-stage shared bitwise datapath: S1 captures the issued op, S2 evaluates and registers the tagged result.
module bm_logic_unit
  import bm_logic_rr_sched_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int IDW  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            vld,
  input  logic [IDW-1:0]  id,
  input  logic [1:0]      op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            s1_vld,
  output logic            res_valid,
  output logic [IDW-1:0]  res_id,
  output logic [BITS-1:0] res_data
);

  logic            s1_vld_r;
  logic [IDW-1:0]  s1_id_r;
  logic [1:0]      s1_op_r;
  logic [BITS-1:0] s1_a_r;
  logic [BITS-1:0] s1_b_r;
  logic            res_valid_r;
  logic [IDW-1:0]  res_id_r;
  logic [BITS-1:0] res_data_r;

  function automatic logic [BITS-1:0] logic_op(input logic [1:0] f_op,
                                               input logic [BITS-1:0] f_a,
                                               input logic [BITS-1:0] f_b);
    case (op_e'(f_op))
      OP_AND:  logic_op = f_a & f_b;
      OP_OR:   logic_op = f_a | f_b;
      OP_XOR:  logic_op = f_a ^ f_b;
      OP_ANDN: logic_op = f_a & ~f_b;
      default: logic_op = '0;
    endcase
  endfunction

  // S1: capture the granted operation; payload only moves when a new op arrives
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld_r <= 1'b0;
      s1_id_r  <= '0;
      s1_op_r  <= 2'b00;
      s1_a_r   <= '0;
      s1_b_r   <= '0;
    end else begin
      s1_vld_r <= vld;
      if (vld) begin
        s1_id_r <= id;
        s1_op_r <= op;
        s1_a_r  <= a;
        s1_b_r  <= b;
      end
    end
  end

  // S2: result register; id/data keep their last value on idle cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid_r <= 1'b0;
      res_id_r    <= '0;
      res_data_r  <= '0;
    end else begin
      res_valid_r <= s1_vld_r;
      if (s1_vld_r) begin
        res_id_r   <= s1_id_r;
        res_data_r <= logic_op(s1_op_r, s1_a_r, s1_b_r);
      end
    end
  end

  assign s1_vld    = s1_vld_r;
  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res_data  = res_data_r;

endmodule

// File: rtl/bm_logic_rr_sched.sv
// Round-robin arbiter issuing at most one requester op per cycle into a shared pipelined logic unit.
module bm_logic_rr_sched
  import bm_logic_rr_sched_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*BITS-1:0] a_bus,
  input  logic [NREQ*BITS-1:0] b_bus,
  input  logic [NREQ*2-1:0] op_bus,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [BITS-1:0]   res_data,
  output logic              busy
);

  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  idx_s;
  logic [IDW-1:0]  gnt_id_s;
  logic            found_s;
  logic [BITS-1:0] a_sel_s;
  logic [BITS-1:0] b_sel_s;
  logic [1:0]      op_sel_s;
  logic            s1_vld_s;

  // Priority scan starting at the pointer; reset and hold suppress any grant
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    idx_s    = '0;
    if (!reset && !hold) begin
      for (int i = 0; i < NREQ; i++) begin
        idx_s = ptr_r + IDW'(i);
        if (!found_s && req[idx_s]) begin
          found_s  = 1'b1;
          gnt_id_s = idx_s;
        end else begin
          found_s  = found_s;
          gnt_id_s = gnt_id_s;
        end
      end
    end else begin
      found_s  = 1'b0;
      gnt_id_s = '0;
    end
  end

  assign gnt      = found_s ? (NREQ'(1) << gnt_id_s) : '0;
  assign a_sel_s  = a_bus[int'(gnt_id_s)*BITS +: BITS];
  assign b_sel_s  = b_bus[int'(gnt_id_s)*BITS +: BITS];
  assign op_sel_s = op_bus[int'(gnt_id_s)*2 +: 2];

  // Pointer moves just past the winner so it drops to lowest priority next cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= gnt_id_s + IDW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  bm_logic_unit #(
    .BITS (BITS),
    .IDW  (IDW)
  ) u_unit (
    .clock     (clock),
    .reset     (reset),
    .vld       (found_s),
    .id        (gnt_id_s),
    .op        (op_sel_s),
    .a         (a_sel_s),
    .b         (b_sel_s),
    .s1_vld    (s1_vld_s),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data)
  );

  assign busy = (|req) | s1_vld_s | res_valid;

endmodule

// File: tb/tb_bm_logic_rr_sched.sv
// Self-checking bench: directed tables and sequences plus random traffic against a queue-based reference model.
module tb_bm_logic_rr_sched;

  localparam int BITS = 2;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 hold  = 1'b0;
  logic [NREQ-1:0]      req   = '0;
  logic [NREQ*BITS-1:0] a_bus = '0;
  logic [NREQ*BITS-1:0] b_bus = '0;
  logic [NREQ*2-1:0]    op_bus = '0;
  logic [NREQ-1:0]      gnt;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [BITS-1:0]      res_data;
  logic                 busy;

  bm_logic_rr_sched #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW)) dut (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .op_bus    (op_bus),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int id;
    int data;
  } item_t;

  typedef struct {
    logic [1:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] exp;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  int    m_ptr  = 0;
  int    m_last_id   = 0;
  int    m_last_data = 0;
  item_t m_q[$];
  vec_t  tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int f_op(input int op, input int a, input int b);
    case (op)
      0:       f_op = a & b;
      1:       f_op = a | b;
      2:       f_op = a ^ b;
      default: f_op = a & ~b & 3;
    endcase
  endfunction

  // Reference: spec-level arbitration and a due-cycle result queue
  task automatic model_check();
    int win;
    int idx;
    int ev;
    int eid;
    int ed;
    int eb;
    if (reset) begin
      m_q.delete();
      m_ptr = 0;
      m_last_id = 0;
      m_last_data = 0;
      chk("gnt_in_reset", gnt, 0);
      chk("res_valid_in_reset", res_valid, 0);
      chk("res_id_in_reset", res_id, 0);
      chk("res_data_in_reset", res_data, 0);
      chk("busy_in_reset", busy, (req != 0) ? 1 : 0);
    end else begin
      win = -1;
      if (!hold) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (win < 0 && req[idx]) win = idx;
        end
      end
      eb = ((req != 0) || (m_q.size() > 0)) ? 1 : 0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        ev = 1;
        m_last_id = m_q[0].id;
        m_last_data = m_q[0].data;
        void'(m_q.pop_front());
      end else begin
        ev = 0;
      end
      eid = m_last_id;
      ed  = m_last_data;
      chk("gnt", gnt, (win < 0) ? 0 : (1 << win));
      chk("res_valid", res_valid, ev);
      chk("res_id", res_id, eid);
      chk("res_data", res_data, ed);
      chk("busy", busy, eb);
      if (win >= 0) begin
        m_q.push_back('{due: cyc + 2, id: win,
                        data: f_op(op_bus[win*2 +: 2], a_bus[win*BITS +: BITS], b_bus[win*BITS +: BITS])});
        m_ptr = (win + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  // One cycle: inputs already applied; exp_rid=-2 demands no result this cycle
  task automatic tick(input int exp_gnt = -1, input int exp_rid = -1, input int exp_rdata = -1);
    #4;
    model_check();
    if (exp_gnt >= 0) chk("tbl_gnt", gnt, exp_gnt);
    if (exp_rid == -2) chk("tbl_no_res", res_valid, 0);
    if (exp_rid >= 0) begin
      chk("tbl_res_valid", res_valid, 1);
      chk("tbl_res_id", res_id, exp_rid);
    end
    if (exp_rdata >= 0) chk("tbl_res_data", res_data, exp_rdata);
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    op_bus[i*2 +: 2]    = op;
    a_bus[i*BITS +: BITS] = a;
    b_bus[i*BITS +: BITS] = b;
  endtask

  initial begin
    tbl[0] = '{op: 2'b11, a: 2'b10, b: 2'b11, exp: 2'b00};
    tbl[1] = '{op: 2'b00, a: 2'b10, b: 2'b11, exp: 2'b10};
    tbl[2] = '{op: 2'b01, a: 2'b10, b: 2'b11, exp: 2'b11};
    tbl[3] = '{op: 2'b10, a: 2'b10, b: 2'b11, exp: 2'b01};

    // Reset with all requesters active, then round robin
    for (int i = 0; i < NREQ; i++) set_op(i, 2'(i), 2'(i), 2'(3 - i));
    req = 4'b1111;
    tick(0, -2);
    tick(0, -2);
    reset = 1'b0;
    for (int j = 0; j < 10; j++) tick(1 << (j % 4), (j >= 2) ? (j - 2) % 4 : -1);
    req = 4'b0000;
    tick();
    tick();

    // Opcode/latency table through requester 2
    for (int v = 0; v < 4; v++) begin
      set_op(2, tbl[v].op, tbl[v].a, tbl[v].b);
      req = 4'b0100;
      tick(4'b0100);
      req = 4'b0000;
      tick(0);
      tick(0, 2, tbl[v].exp);
    end

    // Hold: op issued just before hold still returns; pointer frozen
    set_op(0, 2'b10, 2'b01, 2'b11);
    req = 4'b0011;
    tick(4'b0001);
    hold = 1'b1;
    tick(0);
    tick(0, 0, 2);
    tick(0);
    hold = 1'b0;
    tick(4'b0010);
    req = 4'b0000;
    tick();
    tick();

    // Wrap and skip from pointer 3
    reset = 1'b1;
    tick(0, -2);
    reset = 1'b0;
    req = 4'b0100;
    tick(4'b0100);
    req = 4'b0101;
    tick(4'b0001);
    tick(4'b0100);
    tick(4'b0001);
    req = 4'b0000;
    tick();
    tick();

    // Reset one cycle after a grant drops the in-flight op
    req = 4'b0001;
    tick(4'b0001);
    req = 4'b0000;
    reset = 1'b1;
    tick(0, -2);
    reset = 1'b0;
    tick(0, -2);
    tick(0, -2);
    tick(0, -2);
    set_op(1, 2'b01, 2'b10, 2'b01);
    req = 4'b0010;
    tick(4'b0010);
    req = 4'b0000;
    tick(0, -2);
    tick(0, 1, 3);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 99) == 0);
      hold   = ($urandom_range(0, 3) == 0);
      req    = 4'($urandom_range(0, 15));
      a_bus  = 8'($urandom);
      b_bus  = 8'($urandom);
      op_bus = 8'($urandom);
      tick();
    end
    reset = 1'b0;
    hold  = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
